// File: rtl/burst_line_adapter.sv
// burst_line_adapter
//   Turns one cache-line read or write from the I/D arbiter into a burst of
//   BEATS beats of BEAT_W bits on the bmem port. Only one transaction is in
//   flight at a time, and the adapter buffers no more than one line.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   line_address   line address from the arbiter (byte offset bits ignored)
//   line_read      line read request, held until line_resp
//   line_write     line write request, held until line_resp
//   line_wdata     line to write, held until line_resp
//   line_rdata     assembled read line (registered)
//   line_resp      one-cycle completion pulse
//   bmem_address   line-aligned burst address
//   bmem_read      burst read request
//   bmem_write     burst write request
//   bmem_wdata     current write beat
//   bmem_rdata     current read beat
//   bmem_resp      one pulse per accepted/valid beat
//   timeout_err    sticky watchdog flag (present only with BMEM_TIMEOUT_EN)
//
// Optional feature (macro BMEM_TIMEOUT_EN): a watchdog counts RD/WR cycles
// without bmem_resp. When the count reaches TIMEOUT_CYCLES it sets
// timeout_err and forces completion. line_rdata then keeps the beats that
// had already arrived. Without the macro the adapter waits indefinitely.
module burst_line_adapter #(
  parameter int unsigned BEAT_W         = 64,
  parameter int unsigned BEATS          = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         line_address,
  input  logic                      line_read,
  input  logic                      line_write,
  input  logic [BEAT_W*BEATS-1:0]   line_wdata,
  output logic [BEAT_W*BEATS-1:0]   line_rdata,
  output logic                      line_resp,
  output logic [ADDR_W-1:0]         bmem_address,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [BEAT_W-1:0]         bmem_wdata,
  input  logic [BEAT_W-1:0]         bmem_rdata,
`ifdef BMEM_TIMEOUT_EN
  input  logic                      bmem_resp,
  output logic                      timeout_err
`else
  input  logic                      bmem_resp
`endif
);

  localparam int unsigned LINE_W = BEAT_W * BEATS;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BCNT_W-1:0]   beat;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                timeout_hit;

  // ---------------------------------------------------------------- watchdog
`ifdef BMEM_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 10;
  logic [TO_W-1:0] to_cnt;

  // The hit fires on the cycle that would bring the count to TIMEOUT_CYCLES.
  // Both the flag and the DONE transition therefore land on the same edge.
  assign timeout_hit = ((state == RD) || (state == WR)) && !bmem_resp &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (((state == RD) || (state == WR)) && !bmem_resp && !timeout_hit)
        to_cnt <= to_cnt + TO_W'(1);
      else
        to_cnt <= '0;
      if (timeout_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ------------------------------------------------------------ state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (line_read)       state_next = RD;   // a read wins over a write
        else if (line_write) state_next = WR;
      end
      RD, WR: begin
        if ((bmem_resp && (beat == LAST_BEAT)) || timeout_hit)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      beat       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          beat <= '0;
          if (line_read || line_write) begin
            addr_q  <= {line_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_q <= line_wdata;
          end
        end
        RD: begin
          if (bmem_resp) begin
            line_rdata[beat*BEAT_W +: BEAT_W] <= bmem_rdata;
            beat <= beat + BCNT_W'(1);
          end
        end
        WR: begin
          if (bmem_resp)
            beat <= beat + BCNT_W'(1);
        end
        DONE:    beat <= '0;
        default: beat <= '0;
      endcase
    end
  end

  // ------------------------------------------------------------------- outputs
  // The outputs decode only the state and the registers. No line_* input
  // reaches a bmem_* output through a combinational path.
  always_comb begin
    bmem_read    = (state == RD);
    bmem_write   = (state == WR);
    line_resp    = (state == DONE);
    bmem_address = addr_q;
    bmem_wdata   = '0;
    if (state == WR)
      bmem_wdata = wdata_q[beat*BEAT_W +: BEAT_W];
  end

endmodule

// File: tb/tb_burst_line_adapter.sv
module tb_burst_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic [63:0]  bmem_rdata;
  logic         bmem_resp;
`ifdef BMEM_TIMEOUT_EN
  logic         timeout_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef BMEM_TIMEOUT_EN
  burst_line_adapter #(.TIMEOUT_CYCLES(16)) dut (
`else
  burst_line_adapter dut (
`endif
    .clk(clk), .rst(rst),
    .line_address(line_address), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata),
`ifdef BMEM_TIMEOUT_EN
    .bmem_resp(bmem_resp), .timeout_err(timeout_err)
`else
    .bmem_resp(bmem_resp)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] wline;
    logic [255:0] rline;      // beats returned by memory, beat 0 in [63:0]
    int unsigned  gap;        // idle cycles between bmem_resp pulses
    int unsigned  exp_lat;    // request cycle = 1; 0 means unchecked
    logic [255:0] exp_rdata;  // line_rdata after completion
  } vec_t;

  vec_t vecs[5];

  // Called at a negedge with the DUT in IDLE. It returns at the negedge
  // after the line_resp pulse, which is the IDLE cycle that follows DONE.
  task automatic run_txn(input vec_t v, input int unsigned idx);
    int unsigned cyc;
    int unsigned k;
    int unsigned w;
    bit          done;
    bit          first;
    logic [63:0] wb;
    logic [63:0] rb;
    cyc = 1; k = 0; w = 0; done = 0; first = 1;
    line_read    = v.rd;
    line_write   = v.wr;
    line_address = v.addr;
    line_wdata   = v.wline;
    bmem_resp    = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bmem_read && bmem_write)
        chk($sformatf("v%0d_rw_overlap", idx), 1'b1, 1'b0);
      if (bmem_resp) begin k++; w = 0; end
      if (line_resp) begin
        done = 1;
        bmem_resp = 1'b0;
      end else if (bmem_read || bmem_write) begin
        if (first) begin
          chk($sformatf("v%0d_addr", idx), bmem_address, v.exp_addr);
          first = 0;
        end
        chk($sformatf("v%0d_op", idx), {bmem_read, bmem_write}, v.rd ? 2'b10 : 2'b01);
        if (v.wr && !v.rd) begin
          wb = v.wline[k*64 +: 64];
          chk($sformatf("v%0d_wbeat%0d", idx, k), bmem_wdata, wb);
        end
        if (w >= v.gap && k < 4) begin
          rb = v.rline[k*64 +: 64];
          bmem_rdata = rb;
          bmem_resp  = 1'b1;
        end else begin
          bmem_resp = 1'b0;
          w++;
        end
      end else begin
        bmem_resp = 1'b0;
      end
    end
    if (!done) chk($sformatf("v%0d_resp_timeout", idx), 1'b0, 1'b1);
    chk($sformatf("v%0d_beats", idx), k, 4);
    chk($sformatf("v%0d_rdata", idx), line_rdata, v.exp_rdata);
    if (v.exp_lat != 0) chk($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
    line_read  = 1'b0;
    line_write = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_resp_pulse", idx), line_resp, 1'b0);
  endtask

  initial begin
    rst = 1'b1; line_read = 0; line_write = 0; line_address = '0;
    line_wdata = '0; bmem_rdata = '0; bmem_resp = 0;

    vecs[0] = '{rd: 1, wr: 0, addr: 32'h0000_1234, exp_addr: 32'h0000_1220, wline: '0,
                rline: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                gap: 0, exp_lat: 6,
                exp_rdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{rd: 0, wr: 1, addr: 32'h0000_201F, exp_addr: 32'h0000_2000,
                wline: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                        64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                rline: '0, gap: 2, exp_lat: 0,
                exp_rdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[2] = '{rd: 1, wr: 1, addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFE0,
                wline: {4{64'hEEEE_EEEE_EEEE_EEEE}},
                rline: {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                        64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
                gap: 1, exp_lat: 0,
                exp_rdata: {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                            64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}};
    vecs[3] = '{rd: 1, wr: 0, addr: 32'h8000_0047, exp_addr: 32'h8000_0040, wline: '0,
                rline: {64'h89AB_CDEF_0123_4567, 64'hFEDC_BA98_7654_3210,
                        64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
                gap: 0, exp_lat: 6,
                exp_rdata: {64'h89AB_CDEF_0123_4567, 64'hFEDC_BA98_7654_3210,
                            64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}};
    vecs[4] = '{rd: 0, wr: 1, addr: 32'h8000_0060, exp_addr: 32'h8000_0060,
                wline: {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                        64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888},
                rline: {4{64'hDEAD_BEEF_DEAD_BEEF}}, gap: 0, exp_lat: 6,
                exp_rdata: {64'h89AB_CDEF_0123_4567, 64'hFEDC_BA98_7654_3210,
                            64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_bmem_read", bmem_read, 1'b0);
    chk("rst_bmem_write", bmem_write, 1'b0);
    chk("rst_line_resp", line_resp, 1'b0);
    chk("rst_bmem_address", bmem_address, 32'h0);
    chk("rst_bmem_wdata", bmem_wdata, 64'h0);
    chk("rst_line_rdata", line_rdata, 256'h0);

    // Reset mid-read with beat = 2. The burst is abandoned.
    line_read = 1'b1; line_address = 32'h0000_0100;
    @(negedge clk);                                  // RD, beat 0
    chk("mid_rd_active", bmem_read, 1'b1);
    bmem_rdata = 64'hA0A0_A0A0_A0A0_A0A0; bmem_resp = 1'b1;
    @(negedge clk);                                  // RD, beat 1
    bmem_rdata = 64'hB1B1_B1B1_B1B1_B1B1;
    @(negedge clk);                                  // RD, beat 2
    chk("mid_rd_partial", line_rdata[127:0], {64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0});
    chk("mid_rd_still_rd", bmem_read, 1'b1);
    bmem_resp = 1'b0; line_read = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_bmem_read", bmem_read, 1'b0);
    chk("mid_rst_line_resp", line_resp, 1'b0);
    chk("mid_rst_address", bmem_address, 32'h0);
    chk("mid_rst_rdata", line_rdata, 256'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (line_resp || bmem_read || bmem_write)
        chk("mid_rst_no_resume", {line_resp, bmem_read, bmem_write}, 3'b000);
    end
    chk("mid_rst_idle_after", {line_resp, bmem_read, bmem_write}, 3'b000);

    // Back-to-back table: each request is raised in the IDLE cycle after DONE.
    for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

`ifdef BMEM_TIMEOUT_EN
    begin
      int unsigned rd_cycles;
      bit          seen;
      rd_cycles = 0; seen = 0;
      line_read = 1'b1; line_address = 32'h0000_0400; bmem_resp = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (timeout_err) seen = 1;
        else if (bmem_read) rd_cycles++;
      end
      chk("to_flag_set", seen, 1'b1);
      chk("to_rd_cycles", rd_cycles, 16);
      chk("to_line_resp", line_resp, 1'b1);
      line_read = 1'b0;
      repeat (5) @(negedge clk);
      chk("to_sticky", timeout_err, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("to_cleared", timeout_err, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
